// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the EX stage. It owns HI/LO.
// Ports: clk, reset (async, active high), Start/MDUOp/A/B (request),
//        Busy (registered, op in flight), HI/LO (architectural registers).
// Optional macro MDU_MACC_EN enables madd/maddu/msub/msubu (codes 7-10).
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MACC_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] sh_hi_q, sh_hi_d;
   logic [31:0] sh_lo_q, sh_lo_d;
   // Cleared for divide by zero so HI/LO survive the full-latency op.
   logic        sh_wr_q, sh_wr_d;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        b_zero;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] s_dvsr;
   logic [31:0] u_dvsr;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic [31:0] divu_q;
   logic [31:0] divu_r;

   // Signed divide goes through magnitudes; this also yields the
   // 0x80000000 / -1 overflow result (LO=0x80000000, HI=0) naturally.
   always_comb begin
      prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      prod_u = {32'd0, A} * {32'd0, B};
      b_zero = (B == 32'd0);
      abs_a  = A[31] ? (~A + 32'd1) : A;
      abs_b  = B[31] ? (~B + 32'd1) : B;
      s_dvsr = b_zero ? 32'd1 : abs_b;
      u_dvsr = b_zero ? 32'd1 : B;
      q_mag  = abs_a / s_dvsr;
      r_mag  = abs_a % s_dvsr;
      div_q  = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
      div_r  = A[31] ? (~r_mag + 32'd1) : r_mag;
      divu_q = A / u_dvsr;
      divu_r = A % u_dvsr;
   end

`ifdef MDU_MACC_EN
   logic [63:0] acc;
   assign acc = {hi_q, lo_q};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sh_hi_d = sh_hi_q;
      sh_lo_d = sh_lo_q;
      sh_wr_d = sh_wr_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               case (MDUOp)
                  OP_MULT: begin
                     {sh_hi_d, sh_lo_d} = prod_s;
                     sh_wr_d = 1'b1;
                     cnt_d   = MUL_LOAD;
                     state_d = S_RUN;
                  end
                  OP_MULTU: begin
                     {sh_hi_d, sh_lo_d} = prod_u;
                     sh_wr_d = 1'b1;
                     cnt_d   = MUL_LOAD;
                     state_d = S_RUN;
                  end
                  OP_DIV: begin
                     sh_hi_d = div_r;
                     sh_lo_d = div_q;
                     sh_wr_d = !b_zero;
                     cnt_d   = DIV_LOAD;
                     state_d = S_RUN;
                  end
                  OP_DIVU: begin
                     sh_hi_d = divu_r;
                     sh_lo_d = divu_q;
                     sh_wr_d = !b_zero;
                     cnt_d   = DIV_LOAD;
                     state_d = S_RUN;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
`ifdef MDU_MACC_EN
                  OP_MADD: begin
                     {sh_hi_d, sh_lo_d} = acc + prod_s;
                     sh_wr_d = 1'b1;
                     cnt_d   = MUL_LOAD;
                     state_d = S_RUN;
                  end
                  OP_MADDU: begin
                     {sh_hi_d, sh_lo_d} = acc + prod_u;
                     sh_wr_d = 1'b1;
                     cnt_d   = MUL_LOAD;
                     state_d = S_RUN;
                  end
                  OP_MSUB: begin
                     {sh_hi_d, sh_lo_d} = acc - prod_s;
                     sh_wr_d = 1'b1;
                     cnt_d   = MUL_LOAD;
                     state_d = S_RUN;
                  end
                  OP_MSUBU: begin
                     {sh_hi_d, sh_lo_d} = acc - prod_u;
                     sh_wr_d = 1'b1;
                     cnt_d   = MUL_LOAD;
                     state_d = S_RUN;
                  end
`endif
                  default: ;
               endcase
               busy_d = (state_d == S_RUN);
            end
         end
         S_RUN: begin
            // Any Start seen here is a protocol violation and is dropped.
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               if (sh_wr_q) begin
                  hi_d = sh_hi_q;
                  lo_d = sh_lo_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         sh_hi_q <= 32'd0;
         sh_lo_q <= 32'd0;
         sh_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sh_hi_q <= sh_hi_d;
         sh_lo_q <= sh_lo_d;
         sh_wr_q <= sh_wr_d;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed plus randomized checks of mdu_unit against a
// longint-arithmetic reference of HI/LO and per-op latency.
module tb_mdu_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
      .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic bit macc_on();
`ifdef MDU_MACC_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Cycles Busy stays high for an op issued in IDLE.
   function automatic int latency(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2) return MC;
      if (op == 4'd3 || op == 4'd4) return DC;
      if (op >= 4'd7 && op <= 4'd10 && macc_on()) return MC;
      return 0;
   endfunction

   task automatic model(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub, acc, r;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      acc = {exp_hi, exp_lo};
      r   = acc;
      case (op)
         4'd1: r = longint'(sa * sb);
         4'd2: r = ua * ub;
         4'd3: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
         4'd4: if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
         4'd5: r = {a, exp_lo};
         4'd6: r = {exp_hi, a};
         default: if (macc_on()) begin
            if (op == 4'd7)  r = acc + longint'(sa * sb);
            if (op == 4'd8)  r = acc + ua * ub;
            if (op == 4'd9)  r = acc - longint'(sa * sb);
            if (op == 4'd10) r = acc - ua * ub;
         end
      endcase
      exp_hi = r[63:32];
      exp_lo = r[31:0];
   endtask

   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      int lat, nb;
      logic early;
      logic [31:0] old_hi, old_lo;
      lat    = latency(op);
      old_hi = exp_hi;
      old_lo = exp_lo;
      model(op, a, b);
      Start = 1'b1; MDUOp = op; A = a; B = b;
      tick();
      Start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
      nb = 0;
      early = 1'b0;
      while (Busy === 1'b1 && nb < 40) begin
         nb++;
         if (HI !== old_hi || LO !== old_lo) early = 1'b1;
         tick();
      end
      check({tag, " busy_cycles"}, 32'(nb), 32'(lat));
      check({tag, " early_update"}, {31'd0, early}, 32'd0);
      check({tag, " HI"}, HI, exp_hi);
      check({tag, " LO"}, LO, exp_lo);
   endtask

   initial begin
      int nb;
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
      tick();
      tick();
      check("reset Busy", {31'd0, Busy}, 32'd0);
      check("reset HI", HI, 32'd0);
      check("reset LO", LO, 32'd0);
      reset = 1'b0;
      tick();

      run_op("mult -2*3", 4'd1, 32'hFFFFFFFE, 32'd3);
      check("mult HI const", HI, 32'hFFFFFFFF);
      check("mult LO const", LO, 32'hFFFFFFFA);

      run_op("multu max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("multu HI const", HI, 32'hFFFFFFFE);
      check("multu LO const", LO, 32'h00000001);

      run_op("div -7/2", 4'd3, 32'hFFFFFFF9, 32'd2);
      check("div LO const", LO, 32'hFFFFFFFD);
      check("div HI const", HI, 32'hFFFFFFFF);

      run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
      check("div ovf LO const", LO, 32'h80000000);
      check("div ovf HI const", HI, 32'd0);

      run_op("mthi 1234", 4'd5, 32'h1234, 32'd0);
      run_op("mtlo 5678", 4'd6, 32'h5678, 32'd0);
      run_op("divu by 0", 4'd4, 32'h99, 32'd0);
      check("divu0 HI const", HI, 32'h1234);
      check("divu0 LO const", LO, 32'h5678);

      run_op("mthi AAAA5555", 4'd5, 32'hAAAA5555, 32'd0);
      check("mthi HI const", HI, 32'hAAAA5555);

      // Start=0 must ignore MDUOp.
      MDUOp = 4'd5; A = 32'h0BAD0BAD;
      tick();
      check("no start HI", HI, exp_hi);
      run_op("nop op0", 4'd0, 32'h1, 32'h2);
      run_op("nop op11", 4'd11, 32'h1, 32'h2);

      // mtlo issued on cycle 2 of a multiply must be dropped.
      model(4'd1, 32'd1000, 32'd77);
      Start = 1'b1; MDUOp = 4'd1; A = 32'd1000; B = 32'd77;
      tick();
      Start = 1'b0;
      tick();
      Start = 1'b1; MDUOp = 4'd6; A = 32'hDEADBEEF;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      nb = 0;
      while (Busy === 1'b1 && nb < 40) begin
         nb++;
         tick();
      end
      check("violate busy_cycles", 32'(nb), 32'(MC - 2));
      check("violate LO", LO, 32'd77000);
      check("violate HI", HI, 32'd0);

      // Async reset on cycle 3 of a divide.
      Start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
      tick();
      Start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("midreset Busy", {31'd0, Busy}, 32'd0);
      check("midreset HI", HI, 32'd0);
      check("midreset LO", LO, 32'd0);
      #1 reset = 1'b0;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      for (int i = 0; i < DC + 2; i++) tick();
      check("post reset Busy", {31'd0, Busy}, 32'd0);
      check("post reset LO", LO, 32'd0);

      run_op("mtlo 10", 4'd6, 32'd10, 32'd0);
`ifdef MDU_MACC_EN
      run_op("madd 3*4", 4'd7, 32'd3, 32'd4);
      check("madd HI const", HI, 32'd0);
      check("madd LO const", LO, 32'd22);
      run_op("msub 1*23", 4'd9, 32'd1, 32'd23);
      check("msub HI const", HI, 32'hFFFFFFFF);
      check("msub LO const", LO, 32'hFFFFFFFF);
`else
      run_op("madd disabled", 4'd7, 32'd3, 32'd4);
      check("madd off LO const", LO, 32'd10);
`endif

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
